// File: rtl/gate_selftest_if.sv
// Stimulus/result bundle between the gate self-test sequencer and its environment.
// master drives start and the gate results; slave is the sequencer itself.
interface gate_selftest_if;
  logic       start;
  logic       a;
  logic       b;
  logic       out_and;
  logic       out_or;
  logic       out_not;
  logic       out_nand;
  logic       out_nor;
  logic       out_xor;
  logic       out_xnor;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic [6:0] fail_vec;

  modport master (
    output start, out_and, out_or, out_not, out_nand, out_nor, out_xor, out_xnor,
    input  a, b, busy, done, pass, err_count, fail_vec
  );

  modport slave (
    input  start, out_and, out_or, out_not, out_nand, out_nor, out_xor, out_xnor,
    output a, b, busy, done, pass, err_count, fail_vec
  );
endinterface

// File: rtl/gate_selftest.sv
// Truth-table sweep sequencer and checker for the two-input basic-gate block.
// Optional GATE_SELFTEST_STOP_ON_FAIL_EN: end the run at the first failing vector.
//
// state  | meaning
// IDLE   | waiting for start after reset
// SETTLE | holding a/b for SETTLE_CYCLES cycles
// CHECK  | one-cycle compare of the seven gate outputs
// DONE   | results held, start restarts a run
module gate_selftest #(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 1
) (
  input logic           clk,
  input logic           rst_n,
  gate_selftest_if.slave gs
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  state_t     state;
  logic [3:0] settle_cnt;
  logic [1:0] vec_idx;
  logic [5:0] loop_cnt;
  logic       a_q;
  logic       b_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [7:0] err_q;
  logic [6:0] fail_q;

  logic [6:0] expected;
  logic [6:0] observed;
  logic [6:0] mism;
  logic [3:0] mism_n;
  logic [8:0] err_sum;
  logic [7:0] err_next;
  logic       last_vec;
  logic       stop_now;

  // bit order matches fail_vec: and, or, not, nand, nor, xor, xnor
  always_comb begin
    expected = {~(a_q ^ b_q), a_q ^ b_q, ~(a_q | b_q), ~(a_q & b_q), ~a_q, a_q | b_q, a_q & b_q};
    observed = {gs.out_xnor, gs.out_xor, gs.out_nor, gs.out_nand, gs.out_not, gs.out_or, gs.out_and};
    mism     = expected ^ observed;
    mism_n   = '0;
    for (int i = 0; i < 7; i++) begin
      mism_n = mism_n + {3'b000, mism[i]};
    end
    err_sum  = {1'b0, err_q} + {5'b00000, mism_n};
    err_next = err_sum[8] ? 8'hFF : err_sum[7:0];
    last_vec = (vec_idx == 2'd3) && (loop_cnt == 6'(LOOPS - 1));
`ifdef GATE_SELFTEST_STOP_ON_FAIL_EN
    stop_now = last_vec || (mism != 7'd0);
`else
    stop_now = last_vec;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      vec_idx    <= '0;
      loop_cnt   <= '0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      fail_q     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (gs.start) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            vec_idx    <= '0;
            loop_cnt   <= '0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            fail_q     <= '0;
          end
        end
        SETTLE: begin
          if (settle_cnt == 4'(SETTLE_CYCLES - 1)) begin
            state <= CHECK;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        CHECK: begin
          err_q  <= err_next;
          fail_q <= fail_q | mism;
          if (stop_now) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (err_next == 8'd0);
          end else begin
            if (vec_idx == 2'd3) begin
              loop_cnt <= loop_cnt + 6'd1;
            end
            vec_idx      <= vec_idx + 2'd1;
            {a_q, b_q}   <= vec_idx + 2'd1;
            settle_cnt   <= '0;
            state        <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign gs.a         = a_q;
  assign gs.b         = b_q;
  assign gs.busy      = busy_q;
  assign gs.done      = done_q;
  assign gs.pass      = pass_q;
  assign gs.err_count = err_q;
  assign gs.fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_selftest.sv
// Randomized self-checking bench for gate_selftest: two instances, faulty gate models,
// results compared against a truth-table reference computed in the bench.
module tb_gate_selftest;

  localparam int S0 = 2;
  localparam int L0 = 1;
  localparam int S1 = 1;
  localparam int L1 = 10;

  logic clk;
  logic rst_n;

  gate_selftest_if if0 ();
  gate_selftest_if if1 ();

  gate_selftest #(.SETTLE_CYCLES(S0), .LOOPS(L0)) dut0 (.clk(clk), .rst_n(rst_n), .gs(if0.slave));
  gate_selftest #(.SETTLE_CYCLES(S1), .LOOPS(L1)) dut1 (.clk(clk), .rst_n(rst_n), .gs(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // per-gate fault mode, 2 bits per gate: 0 good, 1 stuck-0, 2 stuck-1, 3 inverted
  logic [13:0] mode_p [2];
  logic        start_r [2];
  logic [6:0]  outs0, outs1;
  logic        a_s [2], b_s [2], busy_s [2], done_s [2], pass_s [2];
  logic [7:0]  err_s [2];
  logic [6:0]  fv_s [2];

  function automatic logic good_out(input int g, input logic a, input logic b);
    case (g)
      0: return a & b;
      1: return a | b;
      2: return ~a;
      3: return ~(a & b);
      4: return ~(a | b);
      5: return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  function automatic logic faulty(input logic v, input logic [1:0] m);
    case (m)
      2'd0: return v;
      2'd1: return 1'b0;
      2'd2: return 1'b1;
      default: return ~v;
    endcase
  endfunction

  always_comb begin
    outs0 = '0;
    outs1 = '0;
    for (int g = 0; g < 7; g++) begin
      outs0[g] = faulty(good_out(g, if0.a, if0.b), mode_p[0][2*g +: 2]);
      outs1[g] = faulty(good_out(g, if1.a, if1.b), mode_p[1][2*g +: 2]);
    end
  end

  assign if0.start = start_r[0];
  assign if1.start = start_r[1];
  assign {if0.out_xnor, if0.out_xor, if0.out_nor, if0.out_nand, if0.out_not, if0.out_or, if0.out_and} = outs0;
  assign {if1.out_xnor, if1.out_xor, if1.out_nor, if1.out_nand, if1.out_not, if1.out_or, if1.out_and} = outs1;

  assign a_s[0] = if0.a;          assign a_s[1] = if1.a;
  assign b_s[0] = if0.b;          assign b_s[1] = if1.b;
  assign busy_s[0] = if0.busy;    assign busy_s[1] = if1.busy;
  assign done_s[0] = if0.done;    assign done_s[1] = if1.done;
  assign pass_s[0] = if0.pass;    assign pass_s[1] = if1.pass;
  assign err_s[0] = if0.err_count; assign err_s[1] = if1.err_count;
  assign fv_s[0] = if0.fail_vec;  assign fv_s[1] = if1.fail_vec;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outs(input int inst, input string when);
    check($sformatf("%s i%0d a", when, inst), 32'(a_s[inst]), 0);
    check($sformatf("%s i%0d b", when, inst), 32'(b_s[inst]), 0);
    check($sformatf("%s i%0d busy", when, inst), 32'(busy_s[inst]), 0);
    check($sformatf("%s i%0d done", when, inst), 32'(done_s[inst]), 0);
    check($sformatf("%s i%0d pass", when, inst), 32'(pass_s[inst]), 0);
    check($sformatf("%s i%0d err_count", when, inst), 32'(err_s[inst]), 0);
    check($sformatf("%s i%0d fail_vec", when, inst), 32'(fv_s[inst]), 0);
  endtask

  // One complete run from a start pulse, checked edge by edge against the reference sweep.
  task automatic run(input int inst, input logic glitch);
    int s, l, errs, n_done, n_vecs, last_v, exp_err, per;
    logic [6:0] fv, mb;
    logic stopped;
    s = (inst == 0) ? S0 : S1;
    l = (inst == 0) ? L0 : L1;
    per = s + 1;
    errs = 0; fv = '0; n_vecs = 0; last_v = 0; stopped = 1'b0;
    for (int lp = 0; lp < l && !stopped; lp++) begin
      for (int v = 0; v < 4 && !stopped; v++) begin
        logic va, vb;
        va = v[1];
        vb = v[0];
        mb = '0;
        for (int g = 0; g < 7; g++) begin
          if (faulty(good_out(g, va, vb), mode_p[inst][2*g +: 2]) != good_out(g, va, vb)) begin
            mb[g] = 1'b1;
            errs++;
          end
        end
        fv = fv | mb;
        n_vecs++;
        last_v = v;
`ifdef GATE_SELFTEST_STOP_ON_FAIL_EN
        if (mb != 7'd0) stopped = 1'b1;
`endif
      end
    end
    exp_err = (errs > 255) ? 255 : errs;
    n_done = n_vecs * per;

    @(negedge clk);
    start_r[inst] = 1'b1;
    @(posedge clk);
    #1;
    start_r[inst] = 1'b0;
    check($sformatf("i%0d start busy", inst), 32'(busy_s[inst]), 1);
    check($sformatf("i%0d start done", inst), 32'(done_s[inst]), 0);
    check($sformatf("i%0d start err_count", inst), 32'(err_s[inst]), 0);
    check($sformatf("i%0d start fail_vec", inst), 32'(fv_s[inst]), 0);
    check($sformatf("i%0d start ab", inst), 32'({a_s[inst], b_s[inst]}), 0);
    for (int k = 1; k <= n_done; k++) begin
      @(posedge clk);
      #1;
      if (k < n_done && (k % per) == 0)
        check($sformatf("i%0d edge %0d ab", inst, k), 32'({a_s[inst], b_s[inst]}), 32'((k / per) % 4));
      if (k == n_done - 1) begin
        check($sformatf("i%0d edge %0d done early", inst, k), 32'(done_s[inst]), 0);
        check($sformatf("i%0d edge %0d busy", inst, k), 32'(busy_s[inst]), 1);
      end
      start_r[inst] = glitch && (k == 1);
    end
    check($sformatf("i%0d end done", inst), 32'(done_s[inst]), 1);
    check($sformatf("i%0d end busy", inst), 32'(busy_s[inst]), 0);
    check($sformatf("i%0d end pass", inst), 32'(pass_s[inst]), 32'(exp_err == 0));
    check($sformatf("i%0d end err_count", inst), 32'(err_s[inst]), 32'(exp_err));
    check($sformatf("i%0d end fail_vec", inst), 32'(fv_s[inst]), 32'(fv));
    check($sformatf("i%0d end ab hold", inst), 32'({a_s[inst], b_s[inst]}), 32'(last_v));
    repeat (2) @(posedge clk);
    #1;
    check($sformatf("i%0d held done", inst), 32'(done_s[inst]), 1);
    check($sformatf("i%0d held err_count", inst), 32'(err_s[inst]), 32'(exp_err));
  endtask

  function automatic logic [13:0] rand_modes();
    logic [13:0] m;
    int r;
    m = '0;
    for (int g = 0; g < 7; g++) begin
      r = $urandom_range(0, 7);
      if (r >= 5) m[2*g +: 2] = 2'(r - 4);
    end
    return m;
  endfunction

  initial begin
    rst_n = 1'b0;
    start_r[0] = 1'b0;
    start_r[1] = 1'b0;
    mode_p[0] = '0;
    mode_p[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outs(0, "reset");
    check_idle_outs(1, "reset");
    @(negedge clk);
    rst_n = 1'b1;

    run(0, 1'b0);
    mode_p[0] = 14'(1) << 10;
    run(0, 1'b0);
    mode_p[0] = '0;
    run(0, 1'b1);
    mode_p[1] = 14'(3) << 4;
    run(1, 1'b0);
    mode_p[1] = 14'h3FFF;
    run(1, 1'b1);
    mode_p[1] = '0;
    run(1, 1'b0);

    for (int t = 0; t < 24; t++) begin
      int inst;
      inst = int'($urandom_range(0, 1));
      mode_p[inst] = rand_modes();
      run(inst, 1'($urandom_range(0, 1)));
    end

    mode_p[0] = 14'(1) << 10;
    @(negedge clk);
    start_r[0] = 1'b1;
    @(posedge clk);
    #1;
    start_r[0] = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outs(0, "midrun reset");
    @(negedge clk);
    rst_n = 1'b1;
    mode_p[0] = '0;
    run(0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/gate_selftest.md
# gate_selftest

Self-checking sequencer wrapped around the basic-gate block. It drives the gate block's `a`/`b` inputs through the full two-input truth table, waits a programmable settle time, and samples the seven gate outputs. Each sample is compared against the expected Boolean result, and the block accumulates a mismatch count and a per-gate failure mask. It is the clocked upstream stimulus and downstream checker for the combinational gate stage, usable in silicon bring-up and in simulation.

## Interface
- `SETTLE_CYCLES`, default 2: cycles `a`/`b` are held before sampling; legal range 1..15.
- `LOOPS`, default 1: number of full truth-table sweeps per run; legal range 1..63.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  run request, sampled in IDLE or DONE.
- `a`, `b`  out  1 each  stimulus to gate block.
- `out_and`, `out_or`, `out_not`, `out_nand`, `out_nor`, `out_xor`, `out_xnor`  in  1 each  gate-block results.
- `busy`  out  1  high in SETTLE and CHECK.
- `done`  out  1  level, high in DONE.
- `pass`  out  1  high in DONE when `err_count`==0.
- `err_count`  out  8  mismatching (vector, gate) pairs, saturating at 255.
- `fail_vec`  out  7  sticky per-gate mismatch mask: bit0 and, 1 or, 2 not, 3 nand, 4 nor, 5 xor, 6 xnor.

## Operation
- Expected values per gate: and a&b; or a|b; not ~a; nand ~(a&b); nor ~(a|b); xor a^b; xnor ~(a^b).
- Vector order per sweep: index 0..3, with {a,b} = index, giving 00, 01, 10, 11. Sweeps repeat LOOPS times.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE, start=1: clear `err_count`, `fail_vec`, and the vector and loop counters; drive {a,b}=00; go to SETTLE with the settle counter at 0.
- SETTLE: the settle counter increments each cycle. When it reaches SETTLE_CYCLES-1, go to CHECK. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- CHECK (one cycle): compare all seven inputs with the expected values.
  - Each mismatching gate adds 1 to `err_count`, saturating at 255.
  - Each mismatching gate sets its `fail_vec` bit.
  - If this is the last vector of the last loop, go to DONE and hold `a`/`b`.
  - Otherwise advance the vector (3 wraps to 0 and increments the loop counter), drive the new {a,b}, clear the settle counter, and go to SETTLE.
- DONE: `done`=1; `pass`=(`err_count`==0); results hold. start=1 restarts exactly as from IDLE, clearing results.
- start while busy: ignored.
- Inputs are sampled only in CHECK; X/glitches during SETTLE are not observed.

## Timing
- Reset values: state IDLE, `a`=0, `b`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_vec`=0.
- Reset asserted mid-run: all outputs return to reset values immediately, without waiting for a clock edge. The run is lost.
- `a`/`b` are registered outputs and change on the edge entering SETTLE.
- Per-vector latency: SETTLE_CYCLES+1 cycles.
- The start edge is edge 0. `done` rises after edge 4·LOOPS·(SETTLE_CYCLES+1); with defaults this is edge 12.
- `err_count` and `fail_vec` update on the CHECK edge and are visible the following cycle.
- Saturation: at 255, further mismatches leave `err_count` at 255; `fail_vec` still updates.

## Configuration
- `GATE_SELFTEST_STOP_ON_FAIL_EN` defined:
  - A CHECK with any mismatch goes directly to DONE.
  - `a`/`b` hold the failing vector.
  - `err_count` holds that vector's mismatch count (1..7).
- Undefined: the run always completes all 4·LOOPS vectors.

## Test plan
- Correct gate model, defaults, start pulse: {a,b} steps 00, 01, 10, 11 every 3 cycles. `done`=1 at edge 12, `pass`=1, `err_count`=0, `fail_vec`=0.
- `out_xor` stuck at 0, defaults: `err_count`=2 (vectors 01 and 10), `fail_vec`=7'b0100000, `pass`=0.
- `out_not` inverted, LOOPS=3: `err_count`=12, `fail_vec`=7'b0000100, `done` at edge 36.
- `GATE_SELFTEST_STOP_ON_FAIL_EN` defined, `out_xor` stuck at 0: DONE entered from the CHECK of vector 01 (edge 6). `a`=0, `b`=1, `err_count`=1, `fail_vec`=7'b0100000.
- `rst_n` pulled low at edge 5 of a run: `busy`, `done`, `a`, `b`, `err_count` and `fail_vec` are 0 before the next edge, and the state is IDLE. A new start after release gives the full 12-edge run.
- From DONE with failures, restart with start=1 and a correct model: results clear on the restart edge, and the run ends with `pass`=1. A start pulse during SETTLE is ignored and `done` timing is unchanged.
